// File: rtl/iterative_alu_if.sv
// Sequencer <-> iterative ALU handshake bundle: request/operands one way,
// busy/done/results the other.
interface iterative_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, carry
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, carry
  );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: logic/arith ops finish in one cycle, shifts take one cycle
// per bit, and the unsigned multiply takes WIDTH shift-add cycles.
module iterative_alu #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  iterative_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_shl;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic [WIDTH:0]   w_wide;
  logic [WIDTH:0]   w_mul_sum;
  logic [2:0]       w_k;
  logic             w_accept;
  logic             w_last;
  logic             w_is_shift;

  assign w_k        = bus.b[2:0];
  assign w_accept   = bus.start & ~r_busy;
  assign w_last     = (r_cnt == CW'(1));
  assign w_is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR);
  // One shift-add step: add the multiplicand into the high half when the current multiplier bit is set.
  assign w_mul_sum  = {1'b0, r_result_hi} + (r_mb[0] ? {1'b0, r_ma} : {(WIDTH + 1){1'b0}});

  // Single-cycle result and flag for the operands currently on the bus.
  always_comb begin
    w_wide      = {(WIDTH + 1){1'b0}};
    w_alu_res   = bus.a;
    w_alu_carry = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_wide      = {1'b0, bus.a} + {1'b0, bus.b};
        w_alu_res   = w_wide[WIDTH-1:0];
        w_alu_carry = w_wide[WIDTH];
      end
      OP_SUB: begin
        w_wide      = {1'b0, bus.a} - {1'b0, bus.b};
        w_alu_res   = w_wide[WIDTH-1:0];
        w_alu_carry = ~w_wide[WIDTH];
      end
      OP_AND:  w_alu_res = bus.a & bus.b;
      OP_OR:   w_alu_res = bus.a | bus.b;
      OP_XOR:  w_alu_res = bus.a ^ bus.b;
      default: w_alu_res = bus.a;
    endcase
  end

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_shl       <= 1'b0;
      r_ma        <= {WIDTH{1'b0}};
      r_mb        <= {WIDTH{1'b0}};
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_result_hi <= {WIDTH{1'b0}};
            if (bus.op == OP_MUL) begin
              r_ma     <= bus.a;
              r_mb     <= bus.b;
              r_result <= {WIDTH{1'b0}};
              r_carry  <= 1'b0;
              r_cnt    <= CW'(WIDTH);
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else if (w_is_shift && (w_k != 3'd0)) begin
              r_result <= bus.a;
              r_carry  <= 1'b0;
              r_cnt    <= CW'(w_k);
              r_shl    <= (bus.op == OP_SHL);
              r_busy   <= 1'b1;
              r_state  <= S_SHIFT;
            end else begin
              r_result <= w_alu_res;
              r_carry  <= w_alu_carry;
              r_done   <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (r_shl) begin
            {r_carry, r_result} <= {r_result, 1'b0};
          end else begin
            {r_result, r_carry} <= {1'b0, r_result};
          end
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          // Product bits retire into the low half as the accumulator shifts right.
          r_result_hi <= w_mul_sum[WIDTH:1];
          r_result    <= {w_mul_sum[0], r_result[WIDTH-1:1]};
          r_mb        <= {1'b0, r_mb[WIDTH-1:1]};
          r_cnt       <= r_cnt - CW'(1);
          if (w_last) begin
            r_carry <= |w_mul_sum[WIDTH:1];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.carry     = r_carry;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed corner cases plus random ops
// scored against an arithmetic reference model.
module tb_iterative_alu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_res;
  int   exp_hi;
  int   exp_c;

  iterative_alu_if #(.WIDTH(8)) bus ();

  iterative_alu #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: result, high byte, flag and edges after accept until done.
  task automatic model(input int op, input int a, input int b,
                       output int res, output int hi, output int c, output int lat);
    int k;
    int full;
    k   = b % 8;
    hi  = 0;
    c   = 0;
    lat = 0;
    case (op)
      0: begin full = a + b; res = full % 256; c = (full >= 256) ? 1 : 0; end
      1: begin res = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * (1 << k)) % 256; c = ((a * (1 << k)) / 256) % 2; lat = k; end
      6: begin res = a / (1 << k); c = (k == 0) ? 0 : (a / (1 << (k - 1))) % 2; lat = k; end
      default: begin full = a * b; res = full % 256; hi = full / 256; c = (hi != 0) ? 1 : 0; lat = 8; end
    endcase
  endtask

  // Issue one op from just after an edge; optionally pulse an ADD request while busy.
  task automatic run_op(input int op, input int a, input int b, input int inject_at);
    int lat;
    bit seen;
    model(op, a, b, exp_res, exp_hi, exp_c, lat);
    bus.start = 1'b1;
    bus.op    = 3'(op);
    bus.a     = 8'(a);
    bus.b     = 8'(b);
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
        check_eq("latency", 32'(i), 32'(lat));
        check_eq("busy_at_done", 32'(bus.busy), 32'd0);
        check_eq("result", 32'(bus.result), 32'(exp_res));
        check_eq("result_hi", 32'(bus.result_hi), 32'(exp_hi));
        check_eq("carry", 32'(bus.carry), 32'(exp_c));
        break;
      end
      check_eq("busy_while_iter", 32'(bus.busy), 32'd1);
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic idle_check();
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("done_single_pulse", 32'(bus.done), 32'd0);
    check_eq("result_hold", 32'(bus.result), 32'(exp_res));
    check_eq("result_hi_hold", 32'(bus.result_hi), 32'(exp_hi));
    check_eq("carry_hold", 32'(bus.carry), 32'(exp_c));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_result"}, 32'(bus.result), 32'd0);
    check_eq({tag, "_result_hi"}, 32'(bus.result_hi), 32'd0);
    check_eq({tag, "_carry"}, 32'(bus.carry), 32'd0);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 8'hFF, 8'h01, -1);
    idle_check();
    run_op(1, 8'h05, 8'h07, -1);
    run_op(1, 8'h07, 8'h07, -1);
    idle_check();
    run_op(5, 8'h81, 8'h03, -1);
    run_op(6, 8'h81, 8'h01, -1);
    run_op(5, 8'h81, 8'h08, -1);
    run_op(7, 8'hFF, 8'hFF, -1);
    run_op(7, 8'h0F, 8'h03, -1);
    idle_check();
    run_op(7, 8'h5A, 8'hC3, 2);
    idle_check();
    idle_check();

    // Abort a multiply mid-flight with reset.
    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("in_reset");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("no_done_after_abort", 32'(bus.done), 32'd0);
    run_op(0, 8'h02, 8'h03, -1);
    idle_check();

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), -1);
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- 8-bit multi-cycle ALU upstream of the datapath zero-detect stage.
- `result` drives the zero-detect input directly and holds stable between operations, so the downstream flag is steady.
- Single-cycle ops: add, sub, and, or, xor.
- Iterative ops: shifts (one bit per cycle) and unsigned shift-add multiply, with a start/busy/done handshake to the sequencer.

Parameters:
- WIDTH, 8, operand/result width; multiply iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on a rising clk edge while busy=0.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; shift amount is b[2:0]; latched on accept.
- busy  out  1  high while an iterative op is in progress.
- done  out  1  one-cycle pulse when result/result_hi/carry become valid.
- result  out  WIDTH  low result (product low byte for MUL).
- result_hi  out  WIDTH  product high byte for MUL; 0 for every other op.
- carry  out  1  carry/borrow/shift-out/overflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, result_hi=0, carry=0; iteration counter=0.
  - Takes effect immediately, including mid-operation; the aborted op never produces done.
- States: IDLE, SHIFT, MUL. Accept edge E0 = rising edge with start=1 and busy=0.
- ADD/SUB/AND/OR/XOR:
  - Computed and registered at E0; done=1 in the cycle after E0; state stays IDLE; busy never rises.
- ADD: carry = bit WIDTH of a+b.
- SUB: result = a-b mod 2^WIDTH; carry=1 when a>=b (no borrow), else 0.
- AND/OR/XOR: carry=0.
- SHL/SHR with k=b[2:0]:
  - k=0: result=a, carry=0, done after E0 as a single-cycle op.
  - k>0: E0 loads a into result and k into the counter, busy=1, state=SHIFT.
  - Each following edge shifts by one and zero-fills; carry takes the bit shifted out; counter decrements.
  - On the edge where the counter reaches 0: busy=0, done=1, state=IDLE.
  - done is visible after edge E0+k; busy is high for exactly k cycles.
- MUL (unsigned):
  - E0 clears the {result_hi,result} accumulator, latches a and b, sets counter=WIDTH, busy=1, state=MUL.
  - Each edge performs one shift-add step.
  - After edge E0+WIDTH: {result_hi,result}=a*b, carry=|result_hi, busy=0, done=1, state=IDLE.
- Outputs while busy:
  - result/result_hi/carry hold intermediate values and are not valid until done.
  - Downstream samples them only on done.
- Outputs after done: result, result_hi and carry hold until the next accept.
- done:
  - Exactly one cycle wide; never asserted while busy=1.
  - Deasserts on the next edge unless that edge completes another op.
- start while busy=1: ignored; no latch, no effect on the op in progress.
- Back-to-back: start may be high in the same cycle done=1 is high (busy=0 then), and is accepted on that edge.
- Undefined op codes: none; all 8 codes are defined.

Test Plan:
- ADD a=0xFF, b=0x01 -> result=0x00, carry=1, done=1 in the cycle after E0, busy never high.
- SUB a=0x05, b=0x07 -> result=0xFE, carry=0; then SUB a=0x07, b=0x07 -> result=0x00, carry=1, accepted back-to-back in the done cycle.
- SHL a=0x81, b=0x03 -> busy high 3 cycles, done after E0+3, result=0x08, carry=0. SHR a=0x81, b=0x01 -> result=0x40, carry=1, done after E0+1. SHL with b=0x08 (k=0) -> result=0x81, carry=0, done after E0 as a single-cycle op.
- MUL a=0xFF, b=0xFF -> busy 8 cycles, done after E0+8, result=0x01, result_hi=0xFE, carry=1. MUL a=0x0F, b=0x03 -> result=0x2D, result_hi=0x00, carry=0.
- MUL in progress, start pulsed with op=ADD at E0+3 -> ignored; MUL completes with the correct product at E0+8; no extra done.
- rst_n driven low at E0+4 of a MUL, released 2 cycles later -> all outputs 0 immediately, no done pulse; next ADD 0x02+0x03 -> result=0x05.
